// File: rtl/int_ram_ctrl.sv
// int_ram_ctrl
// Ping-pong controller for the two-bank intrinsic-message RAM of the LDPC
// decoder. The channel LLR stream fills one bank while the decoder reads the
// other by random address. Banks swap roles on frame completion (fill side)
// and on dec_done (decode side).
//
// Ports
//   clk, reset            single rising-edge clock, async active-high reset
//   in_valid/in_data      LLR beat stream, accepted when in_ready is high
//   in_ready              fill bank has room (low while reset is asserted)
//   frame_avail           the decode bank holds a complete frame
//   dec_rd_en/dec_rd_addr decoder random-address read request
//   dec_rd_valid/data     read response, fixed latency of one cycle
//   dec_done              decoder releases its bank (single-cycle pulse)
//   fill_bank, dec_bank   current bank roles
//   err                   sticky protocol error
//   ram_*                 per-bank single-port RAM interface (index = bank)
//
// The fill bank is never full and the decode bank is always full whenever
// it is accessed, so a write and a read can never target the same bank in
// the same cycle.

module int_ram_ctrl #(
   parameter int DATA_WIDTH = 5,
   parameter int ADDR_WIDTH = 8,
   parameter int FRAME_LEN  = 256
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 in_valid,
   input  logic [DATA_WIDTH-1:0]                in_data,
   output logic                                 in_ready,
   output logic                                 frame_avail,
   input  logic                                 dec_rd_en,
   input  logic [ADDR_WIDTH-1:0]                dec_rd_addr,
   output logic                                 dec_rd_valid,
   output logic [DATA_WIDTH-1:0]                dec_rd_data,
   input  logic                                 dec_done,
   output logic                                 fill_bank,
   output logic                                 dec_bank,
   output logic                                 err,
   output logic [1:0][ADDR_WIDTH-1:0]           ram_address,
   output logic [1:0][DATA_WIDTH-1:0]           ram_data_in,
   output logic [1:0]                           ram_we,
   output logic [1:0]                           ram_cs,
   input  logic [1:0][DATA_WIDTH-1:0]           ram_data_out
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 1);
   // one extra bit so FRAME_LEN == 2**ADDR_WIDTH is representable
   localparam logic [ADDR_WIDTH:0]   LEN_EXT   = (ADDR_WIDTH + 1)'(FRAME_LEN);

   logic [1:0]            full;
   logic                  wr_bank;
   logic                  rd_bank;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic                  rd_valid_q;
   logic                  rd_bank_q;
   logic                  err_q;

   logic wr_fire;
   logic wr_last;
   logic rd_fire;
   logic rel_fire;
   logic addr_oob;
   logic proto_err;

   assign fill_bank   = wr_bank;
   assign dec_bank    = rd_bank;
   assign frame_avail = full[rd_bank];
   assign err         = err_q;

   // in_ready must read low for the whole time reset is held, not only
   // after the first clock, hence the direct gate with reset.
   assign in_ready = !reset && !full[wr_bank];

   assign wr_fire  = in_valid && in_ready;
   assign wr_last  = wr_fire && (wr_addr == LAST_ADDR);
   assign rd_fire  = dec_rd_en && frame_avail;
   assign rel_fire = dec_done && frame_avail;
   assign addr_oob = {1'b0, dec_rd_addr} >= LEN_EXT;

   assign proto_err = (dec_rd_en && !frame_avail)
                    || (dec_done && !frame_avail)
                    || (rd_fire && addr_oob);

   assign dec_rd_valid = rd_valid_q;
   assign dec_rd_data  = rd_valid_q ? ram_data_out[rd_bank_q] : '0;

   always_comb begin
      ram_cs      = '0;
      ram_we      = '0;
      ram_address = '0;
      ram_data_in = '0;
      if (wr_fire) begin
         ram_cs[wr_bank]      = 1'b1;
         ram_we[wr_bank]      = 1'b1;
         ram_address[wr_bank] = wr_addr;
         ram_data_in[wr_bank] = in_data;
      end
      if (rd_fire) begin
         ram_cs[rd_bank]      = 1'b1;
         ram_address[rd_bank] = dec_rd_addr;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         full       <= '0;
         wr_bank    <= 1'b0;
         rd_bank    <= 1'b0;
         wr_addr    <= '0;
         rd_valid_q <= 1'b0;
         rd_bank_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         if (wr_fire) begin
            if (wr_last) begin
               wr_addr       <= '0;
               full[wr_bank] <= 1'b1;
               wr_bank       <= ~wr_bank;
            end else begin
               wr_addr <= wr_addr + ADDR_WIDTH'(1);
            end
         end

         // Release clears a different bit than a completing write can set:
         // the released bank is full, the bank being written is not.
         if (rel_fire) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= ~rd_bank;
         end

         // rd_bank_q keeps the bank of the issued read so a release in the
         // same cycle does not redirect the returning data.
         rd_valid_q <= rd_fire;
         if (rd_fire) begin
            rd_bank_q <= rd_bank;
         end

         if (proto_err) begin
            err_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_int_ram_ctrl.sv
module tb_int_ram_ctrl;

   localparam int DW = 5;
   localparam int AW = 8;
   localparam int FL = 256;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 in_valid;
   logic [DW-1:0]        in_data;
   logic                 in_ready;
   logic                 frame_avail;
   logic                 dec_rd_en;
   logic [AW-1:0]        dec_rd_addr;
   logic                 dec_rd_valid;
   logic [DW-1:0]        dec_rd_data;
   logic                 dec_done;
   logic                 fill_bank;
   logic                 dec_bank;
   logic                 err;
   logic [1:0][AW-1:0]   ram_address;
   logic [1:0][DW-1:0]   ram_data_in;
   logic [1:0]           ram_we;
   logic [1:0]           ram_cs;
   logic [1:0][DW-1:0]   ram_data_out;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   int_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_LEN(FL)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .frame_avail(frame_avail),
      .dec_rd_en(dec_rd_en), .dec_rd_addr(dec_rd_addr),
      .dec_rd_valid(dec_rd_valid), .dec_rd_data(dec_rd_data),
      .dec_done(dec_done), .fill_bank(fill_bank), .dec_bank(dec_bank),
      .err(err), .ram_address(ram_address), .ram_data_in(ram_data_in),
      .ram_we(ram_we), .ram_cs(ram_cs), .ram_data_out(ram_data_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // two single-port synchronous-read RAM banks
   logic [DW-1:0] bank_mem [2][FL];
   always @(posedge clk) begin
      for (int b = 0; b < 2; b++) begin
         if (ram_cs[b]) begin
            if (ram_we[b]) bank_mem[b][ram_address[b]] <= ram_data_in[b];
            else           ram_data_out[b] <= bank_mem[b][ram_address[b]];
         end
      end
   end

   // reference model: frames are counted, frame k lives in slot k mod 2
   int            m_done;
   int            m_rel;
   int            m_cnt;
   bit            m_err;
   logic [DW-1:0] fdata [2][FL];

   typedef struct {
      logic [DW-1:0] data;
      int            due;
   } exp_t;
   exp_t sbq[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_done = 0;
      m_rel  = 0;
      m_cnt  = 0;
      m_err  = 0;
      sbq.delete();
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, "_in_ready"},     32'(in_ready),     32'd0);
      chk({tag, "_frame_avail"},  32'(frame_avail),  32'd0);
      chk({tag, "_dec_rd_valid"}, 32'(dec_rd_valid), 32'd0);
      chk({tag, "_dec_rd_data"},  32'(dec_rd_data),  32'd0);
      chk({tag, "_fill_bank"},    32'(fill_bank),    32'd0);
      chk({tag, "_dec_bank"},     32'(dec_bank),     32'd0);
      chk({tag, "_err"},          32'(err),          32'd0);
      chk({tag, "_ram_cs"},       32'(ram_cs),       32'd0);
      chk({tag, "_ram_we"},       32'(ram_we),       32'd0);
   endtask

   // One cycle: drive inputs just after negedge, check combinational and
   // status outputs, advance the model at the posedge, return at negedge.
   task automatic step(input logic v, input logic [DW-1:0] d, input logic re,
                       input logic [AW-1:0] ra, input logic dn);
      int         occ;
      int         fb;
      int         db;
      bit         avail;
      bit         acc;
      bit         rd;
      logic [1:0] ecs;
      logic [1:0] ewe;
      exp_t       e;
      in_valid    = v;
      in_data     = d;
      dec_rd_en   = re;
      dec_rd_addr = ra;
      dec_done    = dn;
      #1;
      occ   = m_done - m_rel;
      fb    = m_done % 2;
      db    = m_rel % 2;
      avail = occ > 0;
      acc   = v && (occ < 2);
      rd    = re && avail;
      chk("in_ready",    32'(in_ready),    32'(occ < 2));
      chk("frame_avail", 32'(frame_avail), 32'(avail));
      chk("fill_bank",   32'(fill_bank),   32'(fb));
      chk("dec_bank",    32'(dec_bank),    32'(db));
      chk("err",         32'(err),         32'(m_err));
      ecs = '0;
      ewe = '0;
      if (acc) begin
         ecs[fb] = 1'b1;
         ewe[fb] = 1'b1;
      end
      if (rd) ecs[db] = 1'b1;
      chk("ram_cs", 32'(ram_cs), 32'(ecs));
      chk("ram_we", 32'(ram_we), 32'(ewe));
      if (acc) begin
         chk("wr_addr", 32'(ram_address[fb]), 32'(m_cnt));
         chk("wr_data", 32'(ram_data_in[fb]), 32'(d));
      end
      if (rd) begin
         chk("rd_addr", 32'(ram_address[db]), 32'(ra));
         e.data = fdata[db][ra];
         e.due  = cyc + 1;
         sbq.push_back(e);
      end
      @(posedge clk);
      if ((re || dn) && !avail) m_err = 1;
      if (acc) begin
         fdata[fb][m_cnt] = d;
         m_cnt++;
         if (m_cnt == FL) begin
            m_cnt = 0;
            m_done++;
         end
      end
      if (dn && avail) m_rel++;
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, '0, 1'b0, '0, 1'b0);
   endtask

   task automatic rand_step(input int p_valid, input int p_done_inv);
      step(1'($urandom_range(99) < p_valid), DW'($urandom), 1'($urandom_range(1)),
           AW'($urandom), 1'($urandom_range(p_done_inv - 1) == 0));
   endtask

   // read-response scoreboard
   always @(negedge clk) begin
      if (!reset) begin
         if (sbq.size() > 0 && sbq[0].due == cyc) begin
            chk("rd_valid", 32'(dec_rd_valid), 32'd1);
            chk("rd_data",  32'(dec_rd_data),  32'(sbq[0].data));
            void'(sbq.pop_front());
         end else begin
            chk("rd_idle_valid", 32'(dec_rd_valid), 32'd0);
            chk("rd_idle_data",  32'(dec_rd_data),  32'd0);
         end
      end
   end

   initial begin
      in_valid    = 1'b0;
      in_data     = '0;
      dec_rd_en   = 1'b0;
      dec_rd_addr = '0;
      dec_done    = 1'b0;
      model_reset();

      // reset state, with requests pending to show nothing leaks through
      repeat (3) @(negedge clk);
      in_valid  = 1'b1;
      dec_rd_en = 1'b1;
      #1;
      chk_rst("por");
      in_valid  = 1'b0;
      dec_rd_en = 1'b0;
      reset     = 1'b0;
      @(negedge clk);

      // first frame, data = address
      for (int i = 0; i < FL; i++) step(1'b1, DW'(i), 1'b0, '0, 1'b0);
      idle();

      // back-to-back reads 17 and 200
      step(1'b0, '0, 1'b1, AW'(17), 1'b0);
      step(1'b0, '0, 1'b1, AW'(200), 1'b0);
      idle();
      idle();

      // fill the second bank, then hold in_valid against backpressure
      for (int i = 0; i < FL; i++) step(1'b1, DW'($urandom), 1'b0, '0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b1, DW'($urandom), 1'b0, '0, 1'b0);
      step(1'b1, DW'($urandom), 1'b1, AW'($urandom), 1'b1);
      step(1'b1, DW'($urandom), 1'b0, '0, 1'b0);

      // last beat of a frame together with release of the other bank
      for (int i = 0; i < FL - 2; i++) step(1'b1, DW'($urandom), 1'b0, '0, 1'b0);
      step(1'b1, DW'($urandom), 1'b1, AW'($urandom), 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, AW'($urandom), 1'b0);

      // randomized mix
      for (int i = 0; i < 2000; i++) rand_step(70, 300);

      // reset mid-frame with a read in flight
      for (int i = 0; i < 100; i++) step(1'b1, DW'($urandom), 1'b0, '0, 1'b0);
      in_valid    = 1'b0;
      dec_done    = 1'b0;
      dec_rd_en   = (m_done - m_rel) > 0;
      dec_rd_addr = AW'($urandom);
      @(posedge clk);
      #2;
      reset    = 1'b1;
      in_valid = 1'b1;
      #1;
      chk_rst("mid");
      model_reset();
      @(negedge clk);
      in_valid  = 1'b0;
      dec_rd_en = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      // protocol errors while nothing is available, then a fresh frame
      step(1'b0, '0, 1'b1, AW'($urandom), 1'b0);
      step(1'b0, '0, 1'b0, '0, 1'b1);
      idle();
      for (int i = 0; i < FL; i++) step(1'b1, DW'($urandom), 1'b0, '0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, AW'($urandom), 1'b0);
      for (int i = 0; i < 800; i++) rand_step(80, 150);

      idle();
      idle();
      idle();
      chk("sb_empty", 32'(sbq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/int_ram_ctrl.md
Name: int_ram_ctrl

Overview:
- Ping-pong controller for the two-bank intrinsic-message RAM in the LDPC decoder (two single-port, synchronous-read banks).
- Accepts the channel LLR stream into one bank while the decoder reads the other bank by random address.
- Hands banks over on frame completion and decoder release, so a port is never shared within a cycle.

Parameters:
DATA_WIDTH, 5, width of one intrinsic message (LLR)
ADDR_WIDTH, 8, bank address width
FRAME_LEN, 256, messages per codeword; must satisfy 2 <= FRAME_LEN <= 2**ADDR_WIDTH

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  LLR beat valid
in_data  in  DATA_WIDTH  LLR value
in_ready  out  1  controller can accept a beat
frame_avail  out  1  a full bank is owned by the decoder
dec_rd_en  in  1  decoder read request
dec_rd_addr  in  ADDR_WIDTH  decoder read address
dec_rd_valid  out  1  dec_rd_data valid
dec_rd_data  out  DATA_WIDTH  read data
dec_done  in  1  decoder releases its bank (1-cycle pulse)
fill_bank  out  1  bank currently being filled
dec_bank  out  1  bank currently offered to the decoder
err  out  1  sticky protocol-error flag
ram_address  out  2 x ADDR_WIDTH  per-bank address
ram_data_in  out  2 x DATA_WIDTH  per-bank write data
ram_we  out  2  per-bank write enable
ram_cs  out  2  per-bank chip select
ram_data_out  in  2 x DATA_WIDTH  per-bank read data (valid 1 cycle after a cs read)

Behaviour:
- State registers: full[1:0], wr_bank, rd_bank, wr_addr, rd_valid_q, rd_bank_q, err.
- Reset (async, active-high) clears every state register to 0. Output reset values:
  - in_ready=0 while reset is high, 1 after release.
  - frame_avail=0, dec_rd_valid=0, dec_rd_data=0, fill_bank=0, dec_bank=0, err=0.
  - ram_we=0, ram_cs=0; ram_address and ram_data_in are don't-care.
- Status outputs: fill_bank=wr_bank; dec_bank=rd_bank; frame_avail=full[rd_bank].
- Write path:
  - in_ready = !full[wr_bank].
  - Accept when in_valid && in_ready. In the same cycle, combinationally drive ram_cs[wr_bank]=1, ram_we[wr_bank]=1, ram_address[wr_bank]=wr_addr, ram_data_in[wr_bank]=in_data.
  - On accept, wr_addr increments.
  - When wr_addr==FRAME_LEN-1 on accept: wr_addr<=0, full[wr_bank]<=1, wr_bank<=~wr_bank.
  - With both banks full, in_ready=0 and no beat is accepted (backpressure; no data loss).
- Read path:
  - If dec_rd_en && frame_avail: drive ram_cs[rd_bank]=1, ram_we[rd_bank]=0, ram_address[rd_bank]=dec_rd_addr. Register rd_valid_q<=1, rd_bank_q<=rd_bank.
  - Next cycle: dec_rd_valid=rd_valid_q and dec_rd_data=ram_data_out[rd_bank_q]; otherwise dec_rd_data=0.
  - Fixed latency 1, fully pipelined: one read per cycle.
- Release:
  - dec_done && frame_avail: full[rd_bank]<=0, rd_bank<=~rd_bank.
  - dec_done with !frame_avail is ignored and sets err.
- Port exclusivity: the write bank is never full and the read bank is always full, so both never target the same bank in one cycle. A bank with neither access has cs=0, we=0.
- Simultaneous events:
  - Read plus dec_done in the same cycle: the read is performed on the old rd_bank, and its data is returned next cycle even though the bank is released.
  - Last write into bank A plus dec_done on bank B in the same cycle: both take effect, so B becomes the fill bank and A the decode bank.
  - Last write with both banks ending full: in_ready drops the next cycle.
- Errors (sticky until reset):
  - dec_rd_en with !frame_avail: request ignored, err set.
  - dec_rd_addr >= FRAME_LEN while frame_avail: read is still issued, err set.
- Reset mid-frame: the partial frame is discarded and the next accepted beat is written to bank 0, address 0. An in-flight read result is dropped (dec_rd_valid=0 after reset).

Test Plan:
- Stream 256 beats, data=addr[4:0], no stall -> bank0 written at addresses 0..255; frame_avail=1 the cycle after beat 255; fill_bank=1; dec_bank=0.
- With frame 0 available, read addr 17 then addr 200 back-to-back -> dec_rd_valid on the following two cycles with data 17 and 8; ram_cs[1] stays 0 during the reads.
- Fill both banks (512 beats) with no dec_done -> in_ready=0 after beat 511; held in_valid causes no writes. Pulse dec_done -> dec_bank=1 and in_ready=1 the next cycle; the next beat is written to bank0 address 0.
- Same cycle: last beat of the bank1 frame plus dec_done on bank0 -> full[1]=1, full[0]=0, fill_bank=0, dec_bank=1, frame_avail stays 1.
- dec_rd_en with frame_avail=0 -> no ram_cs asserted, err=1; err stays 1 until reset.
- Assert reset after 100 beats -> all outputs at reset values immediately (async); after release, the next beat goes to bank0 address 0, and 256 further beats are needed for frame_avail.
